// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// It forwards grants with one cycle of latency, counts dropped r0 writes and flags read-after-write hazards.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              hazard1,
  output logic              hazard2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_grant,
  output logic [7:0]        drop_count
);

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        drop_count_q, drop_count_d;

  logic              grant_a, grant_b, grant_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_zero;

  // A tie goes to whichever requester was not granted most recently.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !stall) begin
      grant_a = a_valid && (!b_valid || last_grant_q);
      grant_b = b_valid && (!a_valid || !last_grant_q);
    end
  end

  assign grant_any = grant_a || grant_b;
  assign sel_addr  = grant_b ? b_addr : a_addr;
  assign sel_data  = grant_b ? b_data : a_data;
  assign sel_zero  = (sel_addr == '0);

  always_comb begin
    wr_en_d      = grant_any && !sel_zero;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    drop_count_d = drop_count_q;
    if (grant_any) begin
      last_grant_d = grant_b;
      if (sel_zero) begin
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end else begin
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_grant_q <= 1'b1;
      drop_count_q <= 8'd0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
      drop_count_q <= drop_count_d;
    end
  end

  // r0 is hardwired, so reads of it never carry a hazard.
  assign hazard1 = (rd1_addr != '0) &&
                   ((a_valid && a_addr == rd1_addr) ||
                    (b_valid && b_addr == rd1_addr) ||
                    (wr_en_q && wr_addr_q == rd1_addr));
  assign hazard2 = (rd2_addr != '0) &&
                   ((a_valid && a_addr == rd2_addr) ||
                    (b_valid && b_addr == rd2_addr) ||
                    (wr_en_q && wr_addr_q == rd2_addr));

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign last_grant = last_grant_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset, stall;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, rd1_addr, rd2_addr, wr_addr;
  logic [31:0] a_data, b_data, wr_data;
  logic        hazard1, hazard2, wr_en, last_grant;
  logic [7:0]  drop_count;

  int n_chk = 0;
  int n_err = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .hazard1(hazard1), .hazard2(hazard2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_grant(last_grant), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    rd1_addr = '0; rd2_addr = '0;

    // reset values, and no grant while reset is high
    a_valid = 1'b1; a_addr = 5'd3;
    tick(); tick();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_last", last_grant, 1);
    chk("rst_drop", drop_count, 0);
    a_valid = 1'b0;
    reset = 1'b0;
    #1;

    // single write from A, latency 1, one-cycle pulse
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h0000_000F;
    #1;
    chk("single_a_ready", a_ready, 1);
    chk("single_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0;
    #1;
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_addr", wr_addr, 4);
    chk("single_wr_data", wr_data, 32'hF);
    chk("single_last", last_grant, 0);
    tick();
    chk("single_wr_en_off", wr_en, 0);
    chk("single_addr_hold", wr_addr, 4);
    chk("single_data_hold", wr_data, 32'hF);

    // round robin with both requesters valid
    do_reset();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_a_ready%0d", i), a_ready, (i % 2 == 0));
      chk($sformatf("rr_b_ready%0d", i), b_ready, (i % 2 == 1));
      tick();
      chk($sformatf("rr_last%0d", i), last_grant, (i % 2));
      chk($sformatf("rr_wr_en%0d", i), wr_en, 1);
      chk($sformatf("rr_wr_addr%0d", i), wr_addr, (i % 2 == 0) ? 5 : 6);
      chk($sformatf("rr_wr_data%0d", i), wr_data, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // stall blocks grants, A wins after stall when last_grant=1
    do_reset();
    stall = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_a_ready%0d", i), a_ready, 0);
      chk($sformatf("stall_b_ready%0d", i), b_ready, 0);
      tick();
      chk($sformatf("stall_wr_en%0d", i), wr_en, 0);
    end
    stall = 1'b0;
    #1;
    chk("unstall_a_ready", a_ready, 1);
    chk("unstall_b_ready", b_ready, 0);
    tick();
    stall = 1'b1;
    #1;
    chk("stall_keeps_write", wr_en, 1);
    chk("stall_keeps_addr", wr_addr, 5);
    tick();
    chk("stall_after_write", wr_en, 0);
    stall = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    // writes to r0 are accepted, not written, and counted with saturation
    do_reset();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hDEAD;
    #1;
    chk("drop_b_ready", b_ready, 1);
    tick();
    chk("drop_wr_en", wr_en, 0);
    chk("drop_count1", drop_count, 1);
    chk("drop_last", last_grant, 1);
    for (int i = 0; i < 299; i++) tick();
    chk("drop_sat", drop_count, 255);
    chk("drop_wr_en_sat", wr_en, 0);
    chk("drop_addr_hold", wr_addr, 0);
    b_valid = 1'b0;

    // hazard detection
    do_reset();
    stall = 1'b1; a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    rd1_addr = 5'd7; rd2_addr = 5'd0;
    #1;
    chk("haz1_pending", hazard1, 1);
    chk("haz2_r0", hazard2, 0);
    b_valid = 1'b1; b_addr = 5'd3; rd2_addr = 5'd3;
    #1;
    chk("haz2_b", hazard2, 1);
    b_valid = 1'b0;
    #1;
    chk("haz2_clear", hazard2, 0);
    stall = 1'b0;
    tick();
    a_valid = 1'b0;
    #1;
    chk("haz1_inflight", hazard1, 1);
    chk("haz_wr_addr", wr_addr, 7);
    tick();
    chk("haz1_retired", hazard1, 0);

    // reset mid-operation discards the registered write, then re-arbitrates
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    #1;
    chk("mid_a_ready", a_ready, 1);
    tick();
    chk("mid_wr_en_pre", wr_en, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_no_grant", a_ready, 0);
    tick();
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_last", last_grant, 1);
    chk("mid_rst_drop", drop_count, 0);
    reset = 1'b0;
    b_valid = 1'b1; b_addr = 5'd2;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of write data on both requesters and on the register-file write port.
REQ-002 Parameter: ADDR_W, 5, register address width (32 architectural registers).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  high blocks all grants this cycle (register file not accepting writes).
REQ-006 a_valid  in  1  requester A (ALU writeback) has a pending write.
REQ-007 a_addr  in  ADDR_W  requester A destination register.
REQ-008 a_data  in  DATA_W  requester A write data.
REQ-009 a_ready  out  1  requester A granted; transfer when a_valid && a_ready.
REQ-010 b_valid, b_addr, b_data, b_ready: same directions, widths and meanings as REQ-006..009, for requester B (load writeback).
REQ-011 rd1_addr, rd2_addr  in  ADDR_W  addresses currently presented to the register-file read ports.
REQ-012 hazard1, hazard2  out  1  read port 1 or 2 targets a register with an outstanding write.
REQ-013 wr_en  out  1  register-file write enable (drives regWriteC).
REQ-014 wr_addr  out  ADDR_W  register-file write address.
REQ-015 wr_data  out  DATA_W  register-file write data.
REQ-016 last_grant  out  1  requester of the most recent grant: 0 = A, 1 = B.
REQ-017 drop_count  out  8  count of accepted writes to register 0, saturating at 255.

Function
REQ-018 The block shall grant at most one requester per cycle; a_ready and b_ready shall never be high together.
REQ-019 Grants are combinational from the current valid, stall, reset and last_grant signals; with stall=1 or reset=1, a_ready=b_ready=0.
REQ-020 With exactly one requester valid and stall=0, that requester shall be granted.
REQ-021 With both valid and stall=0, the requester not equal to last_grant shall be granted (round-robin); no requester waits more than one granted cycle.
REQ-022 On every grant, last_grant shall update at the next edge to the granted requester; with no grant it shall hold.
REQ-023 Requesters hold valid, addr and data stable until ready; the block shall not latch any request without a grant.
REQ-024 A granted transfer with addr != 0 shall produce wr_en=1, wr_addr=addr and wr_data=data on the following cycle, for exactly one cycle (latency 1).
REQ-025 A granted transfer with addr == 0 shall be accepted (ready=1), shall leave wr_en=0 in the following cycle, and shall increment drop_count unless it is 255.
REQ-026 In a cycle with no grant, the next cycle shall have wr_en=0; wr_addr and wr_data shall hold their previous values.
REQ-027 hazard1 = (rd1_addr != 0) && ((a_valid && a_addr == rd1_addr) || (b_valid && b_addr == rd1_addr) || (wr_en && wr_addr == rd1_addr)); the signal is combinational.
REQ-028 hazard2 shall follow the REQ-027 equation with rd2_addr in place of rd1_addr.
REQ-029 Back-to-back grants shall sustain one write per cycle; stall going high shall not cancel a write already registered on wr_en.

Reset
REQ-030 On a reset edge: wr_en=0, wr_addr=0, wr_data=0, last_grant=1 (A wins the first tie), drop_count=0.
REQ-031 A reset asserted mid-operation shall discard any registered write; no write shall appear on the cycle after the reset edge. Requesters still valid after reset shall be re-arbitrated from the reset state.

Verification
REQ-032 Reset, then a_valid=1, a_addr=4, a_data=0x0000000F -> a_ready=1 in the same cycle; next cycle wr_en=1, wr_addr=4, wr_data=0xF; the cycle after, wr_en=0.
REQ-033 Both valid for 4 cycles after reset (A: r5/0x11, B: r6/0x22, each re-presenting a new write after acceptance) -> grant order A, B, A, B; last_grant sequence 0, 1, 0, 1.
REQ-034 b_valid=1, b_addr=0, b_data=0xDEAD -> b_ready=1, next cycle wr_en=0, drop_count=1; after 300 such writes, drop_count=255.
REQ-035 stall=1 with both valid for 3 cycles -> ready=0 and wr_en=0 throughout; stall drops -> A is granted first when last_grant=1.
REQ-036 a_valid=1, a_addr=7, rd1_addr=7, rd2_addr=0 -> hazard1=1, hazard2=0; after the write retires (wr_en low, no valid to r7) -> hazard1=0.
REQ-037 Grant A (r9) at cycle n, reset at edge n+1 -> wr_en=0 at n+1, all outputs at REQ-030 values.
